// File: rtl/bmu_pkg.sv
// ---------------------------------------------------------------------------
// bmu_pkg
// Shared types for the BMU request-side issuer:
//   rtl_alu_pkt_t  - 42-bit one-hot ALU control packet (clz is the MSB,
//                    csr_imm is the LSB)
//   bmu_op_e       - 6-bit compact opcode understood by the issuer
//   bmu_cmd_t      - one queued command {op, a, b, csr_data}
//   issuer_state_e - issuer FSM states
//   bmu_decode()   - opcode -> rtl_alu_pkt_t
//   bmu_op_legal() - opcode range check (0..BMU_OP_LAST)
// ---------------------------------------------------------------------------
package bmu_pkg;

   typedef struct packed {
      logic clz;
      logic ctz;
      logic cpop;
      logic sext_b;
      logic sext_h;
      logic min;
      logic max;
      logic pack;
      logic packu;
      logic packh;
      logic rol;
      logic ror;
      logic grev;
      logic gorc;
      logic zbb;
      logic bset;
      logic bclr;
      logic binv;
      logic bext;
      logic sh1add;
      logic sh2add;
      logic sh3add;
      logic zba;
      logic land;
      logic lor;
      logic lxor;
      logic sll;
      logic srl;
      logic sra;
      logic beq;
      logic bne;
      logic blt;
      logic bge;
      logic add;
      logic sub;
      logic slt;
      logic unsign;
      logic jal;
      logic predict_t;
      logic predict_nt;
      logic csr_write;
      logic csr_imm;
   } rtl_alu_pkt_t;

   typedef enum logic [5:0] {
      OP_ADD    = 6'd0,  OP_SUB,    OP_SLT,    OP_SLTU,
      OP_AND    = 6'd4,  OP_OR,     OP_XOR,
      OP_SLL    = 6'd7,  OP_SRL,    OP_SRA,    OP_ROL,    OP_ROR,
      OP_CLZ    = 6'd12, OP_CTZ,    OP_CPOP,   OP_SEXTB,  OP_SEXTH,
      OP_MIN    = 6'd17, OP_MAX,    OP_MINU,   OP_MAXU,
      OP_PACK   = 6'd21, OP_PACKU,  OP_PACKH,
      OP_SH1ADD = 6'd24, OP_SH2ADD, OP_SH3ADD,
      OP_BSET   = 6'd27, OP_BCLR,   OP_BINV,   OP_BEXT,
      OP_GREV   = 6'd31, OP_GORC,
      OP_CSRW   = 6'd33, OP_CSRWI
   } bmu_op_e;

   localparam int unsigned BMU_OP_LAST = 34;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] csr_data;
   } bmu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } issuer_state_e;

   function automatic logic bmu_op_legal(logic [5:0] op);
      return op <= 6'(BMU_OP_LAST);
   endfunction

   // One function-select bit per opcode, plus the unsign / zba / csr_imm
   // qualifiers where the operation needs them.
   function automatic rtl_alu_pkt_t bmu_decode(bmu_op_e op);
      rtl_alu_pkt_t p;
      p = '0;
      case (op)
         OP_ADD:    p.add    = 1'b1;
         OP_SUB:    p.sub    = 1'b1;
         OP_SLT:    p.slt    = 1'b1;
         OP_SLTU:   begin p.slt = 1'b1; p.unsign = 1'b1; end
         OP_AND:    p.land   = 1'b1;
         OP_OR:     p.lor    = 1'b1;
         OP_XOR:    p.lxor   = 1'b1;
         OP_SLL:    p.sll    = 1'b1;
         OP_SRL:    p.srl    = 1'b1;
         OP_SRA:    p.sra    = 1'b1;
         OP_ROL:    p.rol    = 1'b1;
         OP_ROR:    p.ror    = 1'b1;
         OP_CLZ:    p.clz    = 1'b1;
         OP_CTZ:    p.ctz    = 1'b1;
         OP_CPOP:   p.cpop   = 1'b1;
         OP_SEXTB:  p.sext_b = 1'b1;
         OP_SEXTH:  p.sext_h = 1'b1;
         OP_MIN:    p.min    = 1'b1;
         OP_MAX:    p.max    = 1'b1;
         OP_MINU:   begin p.min = 1'b1; p.unsign = 1'b1; end
         OP_MAXU:   begin p.max = 1'b1; p.unsign = 1'b1; end
         OP_PACK:   p.pack   = 1'b1;
         OP_PACKU:  p.packu  = 1'b1;
         OP_PACKH:  p.packh  = 1'b1;
         OP_SH1ADD: begin p.sh1add = 1'b1; p.zba = 1'b1; end
         OP_SH2ADD: begin p.sh2add = 1'b1; p.zba = 1'b1; end
         OP_SH3ADD: begin p.sh3add = 1'b1; p.zba = 1'b1; end
         OP_BSET:   p.bset   = 1'b1;
         OP_BCLR:   p.bclr   = 1'b1;
         OP_BINV:   p.binv   = 1'b1;
         OP_BEXT:   p.bext   = 1'b1;
         OP_GREV:   p.grev   = 1'b1;
         OP_GORC:   p.gorc   = 1'b1;
         OP_CSRW:   p.csr_write = 1'b1;
         OP_CSRWI:  begin p.csr_write = 1'b1; p.csr_imm = 1'b1; end
         default:   p = '0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bmu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// bmu_cmd_fifo
// Synchronous FIFO holding queued issuer commands. Full/empty come from the
// registered occupancy only, so a full FIFO refuses a push even when a pop
// happens in the same cycle.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write request (ignored when full)
//   pop,  pop_data   read request (ignored when empty), head of queue
//   full, empty      occupancy flags
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width)
// ---------------------------------------------------------------------------
module bmu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 102
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr_q];

   // NOTE: the storage array has no reset; the pointers and count define
   // which entries are valid, and leaving the array unreset keeps it plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/bmu_op_issuer.sv
// ---------------------------------------------------------------------------
// bmu_op_issuer
// Request-side initiator for the BMU datapath. Queues compact opcode
// commands, decodes each into an rtl_alu_pkt_t, issues one op at a time,
// waits BMU_LATENCY cycles, and returns result/error on a response port.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmdValid/cmdReady, cmdOp, cmdA, cmdB, cmdCsrData   command port
//   bmuValidIn, bmuAp, bmuCsrRenIn, bmuCsrRdataIn,
//   bmuAIn, bmuBIn, bmuScanMode                        BMU request side
//   bmuResultFf, bmuError                              BMU result side
//   rspValid/rspReady, rspResult, rspError, rspOp      response port
//   busy                            FSM active or commands queued
//   issueCount, errCount            statistics
// Parameters: DEPTH (FIFO entries), BMU_LATENCY (issue-to-result cycles)
// Optional: define BMU_ISSUER_STATS_EN to build the saturating 16-bit
// issue/error counters; otherwise both stats ports are constant 0.
// ---------------------------------------------------------------------------
module bmu_op_issuer
   import bmu_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int BMU_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [5:0]  cmdOp,
   input  logic [31:0] cmdA,
   input  logic [31:0] cmdB,
   input  logic [31:0] cmdCsrData,
   output logic        bmuValidIn,
   output logic [41:0] bmuAp,
   output logic        bmuCsrRenIn,
   output logic [31:0] bmuCsrRdataIn,
   output logic [31:0] bmuAIn,
   output logic [31:0] bmuBIn,
   output logic        bmuScanMode,
   input  logic [31:0] bmuResultFf,
   input  logic        bmuError,
   output logic        rspValid,
   input  logic        rspReady,
   output logic [31:0] rspResult,
   output logic        rspError,
   output logic [5:0]  rspOp,
   output logic        busy,
   output logic [15:0] issueCount,
   output logic [15:0] errCount
);

   localparam int WCW = (BMU_LATENCY > 1) ? $clog2(BMU_LATENCY) : 1;

   issuer_state_e  state_q, state_d;
   bmu_cmd_t       head;
   bmu_cmd_t       op_q;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_pop;
   logic           head_legal;
   logic           wait_done;
   logic [WCW-1:0] wait_cnt_q;
   logic [31:0]    rsp_result_q;
   logic           rsp_error_q;
   logic [5:0]     rsp_op_q;

   bmu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(bmu_cmd_t))
   ) u_cmd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmdValid),
      .push_data ({cmdOp, cmdA, cmdB, cmdCsrData}),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cmdReady    = !fifo_full;
   assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
   assign head_legal  = bmu_op_legal(head.op);
   assign wait_done   = (wait_cnt_q == '0);
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;
   assign bmuScanMode = 1'b0;
   assign rspResult   = rsp_result_q;
   assign rspError    = rsp_error_q;
   assign rspOp       = rsp_op_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = head_legal ? ST_ISSUE : ST_RESP;
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (wait_done) state_d = ST_RESP;
         ST_RESP:  if (rspReady)  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Operands are visible to the BMU only while the op is in flight.
   always_comb begin
      bmuValidIn    = 1'b0;
      bmuAp         = '0;
      bmuCsrRenIn   = 1'b0;
      bmuCsrRdataIn = '0;
      bmuAIn        = '0;
      bmuBIn        = '0;
      rspValid      = 1'b0;
      unique case (state_q)
         ST_ISSUE: begin
            bmuValidIn    = 1'b1;
            bmuAp         = bmu_decode(bmu_op_e'(op_q.op));
            bmuCsrRenIn   = (op_q.op == OP_CSRW) || (op_q.op == OP_CSRWI);
            bmuCsrRdataIn = op_q.csr_data;
            bmuAIn        = op_q.a;
            bmuBIn        = op_q.b;
         end
         ST_WAIT: begin
            bmuCsrRdataIn = op_q.csr_data;
            bmuAIn        = op_q.a;
            bmuBIn        = op_q.b;
         end
         ST_RESP: rspValid = 1'b1;
         default: ;
      endcase
   end

   // ---------------- op register, latency counter, response capture ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= '0;
         wait_cnt_q   <= '0;
         rsp_result_q <= '0;
         rsp_error_q  <= 1'b0;
         rsp_op_q     <= '0;
      end else begin
         if (fifo_pop) op_q <= head;

         // Loaded during ISSUE so WAIT lasts exactly BMU_LATENCY cycles.
         if (state_q == ST_ISSUE) begin
            wait_cnt_q <= WCW'(BMU_LATENCY - 1);
         end else if ((state_q == ST_WAIT) && !wait_done) begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
         end

         // Illegal opcodes bypass the BMU and answer with a decode error.
         if (fifo_pop && !head_legal) begin
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
            rsp_op_q     <= head.op;
         end else if ((state_q == ST_WAIT) && wait_done) begin
            rsp_result_q <= bmuResultFf;
            rsp_error_q  <= bmuError;
            rsp_op_q     <= op_q.op;
         end
      end
   end

   // ---------------- statistics ----------------
`ifdef BMU_ISSUER_STATS_EN
   logic [15:0] issue_cnt_q;
   logic [15:0] err_cnt_q;
   logic        err_entry;

   // A response with an error is entered either directly from IDLE
   // (decode error) or from the last WAIT cycle (BMU error).
   assign err_entry = (fifo_pop && !head_legal) ||
                      ((state_q == ST_WAIT) && wait_done && bmuError);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if ((state_q == ST_ISSUE) && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
         end
         if (err_entry && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign issueCount = issue_cnt_q;
   assign errCount   = err_cnt_q;
`else
   assign issueCount = '0;
   assign errCount   = '0;
`endif

endmodule

// File: tb/tb_bmu_op_issuer.sv
// ---------------------------------------------------------------------------
// tb_bmu_op_issuer
// Directed bench for bmu_op_issuer with a reference model: a command queue
// that predicts the issue order, the decoded packet and the response of each
// accepted command, and a simple BMU responder driven by the decoded packet.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bmu_op_issuer;
   import bmu_pkg::*;

   localparam int DEPTH = 4;
   localparam int LAT   = 1;
   localparam logic [31:0] MIX_K = 32'h5A5A_0F0F;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmdValid;
   logic        cmdReady;
   logic [5:0]  cmdOp;
   logic [31:0] cmdA;
   logic [31:0] cmdB;
   logic [31:0] cmdCsrData;
   logic        bmuValidIn;
   logic [41:0] bmuAp;
   logic        bmuCsrRenIn;
   logic [31:0] bmuCsrRdataIn;
   logic [31:0] bmuAIn;
   logic [31:0] bmuBIn;
   logic        bmuScanMode;
   logic [31:0] bmuResultFf;
   logic        bmuError;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspResult;
   logic        rspError;
   logic [5:0]  rspOp;
   logic        busy;
   logic [15:0] issueCount;
   logic [15:0] errCount;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bmu_op_issuer #(.DEPTH(DEPTH), .BMU_LATENCY(LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmdValid      (cmdValid),
      .cmdReady      (cmdReady),
      .cmdOp         (cmdOp),
      .cmdA          (cmdA),
      .cmdB          (cmdB),
      .cmdCsrData    (cmdCsrData),
      .bmuValidIn    (bmuValidIn),
      .bmuAp         (bmuAp),
      .bmuCsrRenIn   (bmuCsrRenIn),
      .bmuCsrRdataIn (bmuCsrRdataIn),
      .bmuAIn        (bmuAIn),
      .bmuBIn        (bmuBIn),
      .bmuScanMode   (bmuScanMode),
      .bmuResultFf   (bmuResultFf),
      .bmuError      (bmuError),
      .rspValid      (rspValid),
      .rspReady      (rspReady),
      .rspResult     (rspResult),
      .rspError      (rspError),
      .rspOp         (rspOp),
      .busy          (busy),
      .issueCount    (issueCount),
      .errCount      (errCount)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Packet each opcode must produce, straight from the opcode table.
   function automatic logic [41:0] exp_ap(input logic [5:0] op);
      rtl_alu_pkt_t p;
      p = '0;
      case (op)
         6'd0:  p.add = 1'b1;
         6'd1:  p.sub = 1'b1;
         6'd2:  p.slt = 1'b1;
         6'd3:  begin p.slt = 1'b1; p.unsign = 1'b1; end
         6'd4:  p.land = 1'b1;
         6'd5:  p.lor = 1'b1;
         6'd6:  p.lxor = 1'b1;
         6'd7:  p.sll = 1'b1;
         6'd8:  p.srl = 1'b1;
         6'd9:  p.sra = 1'b1;
         6'd10: p.rol = 1'b1;
         6'd11: p.ror = 1'b1;
         6'd12: p.clz = 1'b1;
         6'd13: p.ctz = 1'b1;
         6'd14: p.cpop = 1'b1;
         6'd15: p.sext_b = 1'b1;
         6'd16: p.sext_h = 1'b1;
         6'd17: p.min = 1'b1;
         6'd18: p.max = 1'b1;
         6'd19: begin p.min = 1'b1; p.unsign = 1'b1; end
         6'd20: begin p.max = 1'b1; p.unsign = 1'b1; end
         6'd21: p.pack = 1'b1;
         6'd22: p.packu = 1'b1;
         6'd23: p.packh = 1'b1;
         6'd24: begin p.sh1add = 1'b1; p.zba = 1'b1; end
         6'd25: begin p.sh2add = 1'b1; p.zba = 1'b1; end
         6'd26: begin p.sh3add = 1'b1; p.zba = 1'b1; end
         6'd27: p.bset = 1'b1;
         6'd28: p.bclr = 1'b1;
         6'd29: p.binv = 1'b1;
         6'd30: p.bext = 1'b1;
         6'd31: p.grev = 1'b1;
         6'd32: p.gorc = 1'b1;
         6'd33: p.csr_write = 1'b1;
         6'd34: begin p.csr_write = 1'b1; p.csr_imm = 1'b1; end
         default: p = '0;
      endcase
      return p;
   endfunction

   // What the bench BMU returns for an opcode, or 0 for an illegal opcode.
   function automatic logic [31:0] model_result(input logic [5:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [31:0] csr);
      if (op > 6'd34) return 32'd0;
      case (op)
         6'd0:         return a + b;
         6'd1:         return a - b;
         6'd3:         return {31'd0, a < b};
         6'd4:         return a & b;
         6'd5:         return a | b;
         6'd6:         return a ^ b;
         6'd33, 6'd34: return csr;
         default:      return a ^ b ^ MIX_K;
      endcase
   endfunction

   function automatic logic model_err(input logic [5:0] op);
      return (op > 6'd34) || (op == 6'd33) || (op == 6'd34);
   endfunction

   // ---------------- BMU responder (1-cycle latency) ----------------
   rtl_alu_pkt_t bus_ap;
   assign bus_ap = bmuAp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bmuResultFf <= '0;
         bmuError    <= 1'b0;
      end else if (bmuValidIn) begin
         bmuError <= bus_ap.csr_write;
         if (bus_ap.add)                     bmuResultFf <= bmuAIn + bmuBIn;
         else if (bus_ap.sub)                bmuResultFf <= bmuAIn - bmuBIn;
         else if (bus_ap.slt && bus_ap.unsign) bmuResultFf <= {31'd0, bmuAIn < bmuBIn};
         else if (bus_ap.land)               bmuResultFf <= bmuAIn & bmuBIn;
         else if (bus_ap.lor)                bmuResultFf <= bmuAIn | bmuBIn;
         else if (bus_ap.lxor)               bmuResultFf <= bmuAIn ^ bmuBIn;
         else if (bus_ap.csr_write)          bmuResultFf <= bmuCsrRdataIn;
         else                                bmuResultFf <= bmuAIn ^ bmuBIn ^ MIX_K;
      end
   end

   // ---------------- scoreboard / compare process ----------------
   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] csr;
   } tcmd_t;

   tcmd_t exp_q[$];   // every accepted command, awaiting its response
   tcmd_t iss_q[$];   // accepted legal commands, awaiting issue
   tcmd_t mon_c;
   int    n_issue = 0;
   int    n_err_rsp = 0;
   int    n_rsp = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         iss_q.delete();
         n_issue   = 0;
         n_err_rsp = 0;
      end else begin
         check("scan_mode", 64'(bmuScanMode), 64'd0);
         if (cmdValid && cmdReady) begin
            mon_c.op  = cmdOp;
            mon_c.a   = cmdA;
            mon_c.b   = cmdB;
            mon_c.csr = cmdCsrData;
            exp_q.push_back(mon_c);
            if (cmdOp <= 6'd34) iss_q.push_back(mon_c);
         end
         if (bmuValidIn) begin
            n_issue++;
            if (iss_q.size() == 0) begin
               check("issue_unexpected", 64'(bmuValidIn), 64'd0);
            end else begin
               mon_c = iss_q.pop_front();
               check("issue_ap",   64'(bmuAp),         64'(exp_ap(mon_c.op)));
               check("issue_a",    64'(bmuAIn),        64'(mon_c.a));
               check("issue_b",    64'(bmuBIn),        64'(mon_c.b));
               check("issue_csr",  64'(bmuCsrRdataIn), 64'(mon_c.csr));
               check("issue_cren", 64'(bmuCsrRenIn),
                     64'((mon_c.op == 6'd33) || (mon_c.op == 6'd34)));
            end
         end else begin
            check("idle_ap_zero", 64'(bmuAp), 64'd0);
         end
         if (rspValid) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 64'(rspValid), 64'd0);
            end else begin
               mon_c = exp_q[0];
               check("rsp_op",     64'(rspOp),     64'(mon_c.op));
               check("rsp_result", 64'(rspResult),
                     64'(model_result(mon_c.op, mon_c.a, mon_c.b, mon_c.csr)));
               check("rsp_error",  64'(rspError),  64'(model_err(mon_c.op)));
               if (rspReady) begin
                  void'(exp_q.pop_front());
                  n_rsp++;
                  if (model_err(mon_c.op)) n_err_rsp++;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_cmd(input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] csr);
      bit done = 1'b0;
      cmdValid   = 1'b1;
      cmdOp      = op;
      cmdA       = a;
      cmdB       = b;
      cmdCsrData = csr;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (cmdReady) done = 1'b1;
      end
      if (!done) check("push_timeout", 64'(cmdReady), 64'd1);
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
   endtask

   task automatic wait_issue(input string name);
      int i = 0;
      @(negedge clk);
      while (!bmuValidIn && i < 60) begin
         @(negedge clk);
         i++;
      end
      check(name, 64'(bmuValidIn), 64'd1);
   endtask

   task automatic wait_rsp(input string name);
      int i = 0;
      @(negedge clk);
      while (!rspValid && i < 60) begin
         @(negedge clk);
         i++;
      end
      check(name, 64'(rspValid), 64'd1);
   endtask

   task automatic wait_idle(input string name);
      int i = 0;
      @(negedge clk);
      while (busy && i < 200) begin
         @(negedge clk);
         i++;
      end
      check(name, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base_issue;
      int base_rsp;
      int cnt;

      rst        = 1'b1;
      cmdValid   = 1'b0;
      cmdOp      = '0;
      cmdA       = '0;
      cmdB       = '0;
      cmdCsrData = '0;
      rspReady   = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmdReady),   64'd1);
      check("rst_rsp_valid", 64'(rspValid),   64'd0);
      check("rst_valid_in",  64'(bmuValidIn), 64'd0);
      check("rst_busy",      64'(busy),       64'd0);
      check("rst_result",    64'(rspResult),  64'd0);
      check("rst_issue_cnt", 64'(issueCount), 64'd0);
      check("rst_err_cnt",   64'(errCount),   64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // ADD 5+7: exact latency and one-cycle issue strobe
      rspReady = 1'b1;
      push_cmd(6'd0, 32'd5, 32'd7, 32'd0);
      @(negedge clk);
      check("add_n1_no_issue", 64'(bmuValidIn), 64'd1 - 64'd1);
      @(negedge clk);
      check("add_n2_issue",   64'(bmuValidIn),       64'd1);
      check("add_ap_add",     64'(bus_ap.add),       64'd1);
      check("add_ap_onehot",  64'($countones(bmuAp)), 64'd1);
      @(negedge clk);
      check("add_n3_strobe_low", 64'(bmuValidIn), 64'd0);
      check("add_n3_no_rsp",     64'(rspValid),   64'd0);
      @(negedge clk);
      check("add_n4_rsp",    64'(rspValid),  64'd1);
      check("add_result",    64'(rspResult), 64'h0000_000C);
      check("add_error",     64'(rspError),  64'd0);
      check("add_op",        64'(rspOp),     64'd0);
      @(posedge clk);
      #1;

      // SLTU 0xFFFFFFFF < 1 is false
      push_cmd(6'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
      wait_issue("sltu_issue");
      check("sltu_ap_slt",    64'(bus_ap.slt),    64'd1);
      check("sltu_ap_unsign", 64'(bus_ap.unsign), 64'd1);
      check("sltu_ap_bits",   64'($countones(bmuAp)), 64'd2);
      wait_rsp("sltu_rsp");
      check("sltu_result", 64'(rspResult), 64'd0);
      @(posedge clk);
      #1;

      // Five commands with the response port stalled
      rspReady   = 1'b0;
      base_rsp   = n_rsp;
      push_cmd(6'd0,  32'd1,    32'd2,    32'd0);
      push_cmd(6'd1,  32'd10,   32'd3,    32'd0);
      push_cmd(6'd25, 32'd4,    32'd8,    32'd0);
      push_cmd(6'd19, 32'd9,    32'd6,    32'd0);
      push_cmd(6'd6,  32'hF0,   32'h0F,   32'd0);
      @(negedge clk);
      check("stall_full",     64'(cmdReady), 64'd0);
      check("stall_rsp_held", 64'(rspValid), 64'd1);
      check("stall_rsp_op",   64'(rspOp),    64'd0);
      base_issue = n_issue;
      repeat (8) @(negedge clk);
      check("stall_no_issue",   64'(n_issue - base_issue), 64'd0);
      check("stall_still_full", 64'(cmdReady), 64'd0);
      check("stall_result_hold", 64'(rspResult), 64'd3);
      @(posedge clk);
      #1 rspReady = 1'b1;
      cnt = 0;
      while ((n_rsp - base_rsp) < 5 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("stall_drained", 64'(n_rsp - base_rsp), 64'd5);
      @(posedge clk);
      #1;

      // Illegal opcode: no BMU issue, decode error
      base_issue = n_issue;
      push_cmd(6'd63, 32'd1, 32'd2, 32'd3);
      wait_rsp("illegal_rsp");
      check("illegal_error",    64'(rspError),  64'd1);
      check("illegal_result",   64'(rspResult), 64'd0);
      check("illegal_op",       64'(rspOp),     64'd63);
      check("illegal_no_issue", 64'(n_issue - base_issue), 64'd0);
      @(posedge clk);
      #1;

      // CSRW with the BMU flagging an error
      push_cmd(6'd33, 32'd0, 32'd0, 32'hDEAD_BEEF);
      wait_issue("csrw_issue");
      check("csrw_ren",   64'(bmuCsrRenIn),   64'd1);
      check("csrw_rdata", 64'(bmuCsrRdataIn), 64'hDEAD_BEEF);
      check("csrw_ap",    64'(bus_ap.csr_write), 64'd1);
      wait_rsp("csrw_rsp");
      check("csrw_error", 64'(rspError), 64'd1);
      @(posedge clk);
      #1;
      wait_idle("idle_before_stats");

      // 8 issued ops (ADD, SLTU, 5 queued, CSRW); 2 errors (illegal, CSRW)
      check("model_issue_total", 64'(n_issue),   64'd8);
      check("model_err_total",   64'(n_err_rsp), 64'd2);
`ifdef BMU_ISSUER_STATS_EN
      check("stats_issue", 64'(issueCount), 64'(n_issue));
      check("stats_err",   64'(errCount),   64'(n_err_rsp));
`else
      check("stats_issue_off", 64'(issueCount), 64'd0);
      check("stats_err_off",   64'(errCount),   64'd0);
`endif

      // Reset while an op sits in WAIT
      @(posedge clk);
      #1;
      push_cmd(6'd0, 32'd3, 32'd4, 32'd0);
      wait_issue("rst_mid_issue");
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_rsp_valid", 64'(rspValid),  64'd0);
      check("rst_mid_busy",      64'(busy),      64'd0);
      check("rst_mid_ready",     64'(cmdReady),  64'd1);
      check("rst_mid_a",         64'(bmuAIn),    64'd0);
      check("rst_mid_stats",     64'(issueCount), 64'd0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rspValid) cnt++;
      end
      check("rst_mid_no_rsp", 64'(cnt), 64'd0);
      @(posedge clk);
      #1;
      push_cmd(6'd0, 32'd100, 32'd23, 32'd0);
      wait_rsp("post_rst_rsp");
      check("post_rst_result", 64'(rspResult), 64'd123);
      check("post_rst_error",  64'(rspError),  64'd0);
      @(posedge clk);
      #1;
      wait_idle("final_idle");
`ifdef BMU_ISSUER_STATS_EN
      check("post_rst_issue_cnt", 64'(issueCount), 64'd1);
      check("post_rst_err_cnt",   64'(errCount),   64'd0);
`endif
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
